// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, ALU-op and mux-select definitions for the multicycle MIPS control
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU      = 2'b00;
  localparam logic [1:0] PC_ALUOUT   = 2'b01;
  localparam logic [1:0] PC_JUMP     = 2'b10;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;
  function automatic logic is_legal(input logic [5:0] op);
    return op == OP_LW || op == OP_SW || op == OP_RTYPE || op == OP_BEQ || op == OP_ADDI || op == OP_J;
  endfunction
endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: instruction/memory status in, datapath control word out
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal_op;
  logic [3:0] state_o;
  modport master (
    input  opcode, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op, state_o
  );
  modport slave (
    output opcode, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op, state_o
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: state to control-word decoder; a stalled fetch suppresses the IR/PC loads
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic       rst,
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       stall,
  output ctrl_t      c,
  output logic       illegal_op
);
  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = !stall;
        c.pc_write  = !stall;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_src    = PC_ALU;
      end
      S_DECODE: c.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = PC_ALUOUT;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_JUMP;
      end
      default: c = '0;
    endcase
    c = rst ? '0 : c;
    illegal_op = !rst && state == S_DECODE && !is_legal(opcode);
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS main control FSM (state register and next-state logic)
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  mips_multicycle_ctrl_if.master bus
);
  state_t state, state_n;
  ctrl_t  c;
  logic   stall;
  assign stall = MEM_WAIT_EN && !bus.mem_ready;
  always_ff @(posedge clk)
    state <= rst ? S_FETCH : state_n;
  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:  state_n = stall ? S_FETCH : S_DECODE;
      S_DECODE: state_n = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? S_MEMADR :
                          bus.opcode == OP_RTYPE ? S_EXEC :
                          bus.opcode == OP_BEQ   ? S_BRANCH :
                          bus.opcode == OP_ADDI  ? S_ADDIEX :
                          bus.opcode == OP_J     ? S_JUMP : S_FETCH;
      S_MEMADR: state_n = bus.opcode == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_n = stall ? S_MEMRD : S_MEMWB;
      S_MEMWR:  state_n = stall ? S_MEMWR : S_FETCH;
      S_EXEC:   state_n = S_ALUWB;
      S_ADDIEX: state_n = S_ADDIWB;
      default:  state_n = S_FETCH;
    endcase
  end
  mips_ctrl_outdec u_outdec (
    .rst(rst), .state(state), .opcode(bus.opcode), .stall(stall), .c(c), .illegal_op(bus.illegal_op)
  );
  assign bus.mem_read      = c.mem_read;
  assign bus.mem_write     = c.mem_write;
  assign bus.iord          = c.iord;
  assign bus.ir_write      = c.ir_write;
  assign bus.pc_write      = c.pc_write;
  assign bus.pc_write_cond = c.pc_write_cond;
  assign bus.pc_src        = c.pc_src;
  assign bus.alu_src_a     = c.alu_src_a;
  assign bus.alu_src_b     = c.alu_src_b;
  assign bus.alu_op        = c.alu_op;
  assign bus.reg_write     = c.reg_write;
  assign bus.reg_dst       = c.reg_dst;
  assign bus.mem_to_reg    = c.mem_to_reg;
  assign bus.state_o       = rst ? 4'd0 : state;
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle MIPS main control unit. It is a Moore FSM that sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, beq, addi and j. It drives every datapath enable and mux select. It also produces the 2-bit ALU operation class that the downstream ALU control decoder combines with the instruction funct field.

Parameters:
MEM_WAIT_EN, 1, 1 = FETCH/MEMRD/MEMWR hold until mem_ready; 0 = mem_ready ignored (single-cycle memory).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  instruction bits [31:26] from the instruction register
mem_ready  in  1  memory access completes this cycle
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  out  1  instruction register load
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
alu_src_a  out  1  0 = PC, 1 = register A
alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
alu_op  out  2  00 = add, 01 = sub, 10 = use funct
reg_write  out  1  register file write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
illegal_op  out  1  one-cycle pulse on unsupported opcode
state_o  out  4  current state encoding, for debug and verification

Behaviour:
- Reset is synchronous and active-high: rst sampled high at a clk edge forces state FETCH next cycle. Reset mid-instruction abandons it; no partial writes occur after the reset edge.
- While rst is high, all outputs are driven 0 (including the FETCH strobes); state_o = 0.
- Outputs are pure functions of the state (Moore), except the FETCH pc_write/ir_write gating described below. Any output not listed for a state is 0.
- States and encodings:
  - FETCH(0): mem_read, ir_write, pc_write, alu_src_b = 01, alu_op = 00, pc_src = 00. If MEM_WAIT_EN is 1 and mem_ready is 0, ir_write and pc_write are forced 0 and the FSM stays in FETCH. Otherwise -> DECODE.
  - DECODE(1): alu_src_b = 11, alu_op = 00 (branch target). Next state by opcode:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - anything else -> FETCH, with illegal_op = 1 in the DECODE cycle.
  - MEMADR(2): alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next: lw -> MEMRD, sw -> MEMWR.
  - MEMRD(3): mem_read, iord = 1. Waits on mem_ready when MEM_WAIT_EN = 1; then -> MEMWB.
  - MEMWB(4): reg_write, mem_to_reg = 1, reg_dst = 0 -> FETCH.
  - MEMWR(5): mem_write, iord = 1. Waits on mem_ready; then -> FETCH.
  - EXEC(6): alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> ALUWB.
  - ALUWB(7): reg_write, reg_dst = 1, mem_to_reg = 0 -> FETCH.
  - BRANCH(8): alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond, pc_src = 01 -> FETCH.
  - ADDIEX(9): alu_src_a = 1, alu_src_b = 10, alu_op = 00 -> ADDIWB.
  - ADDIWB(10): reg_write, reg_dst = 0, mem_to_reg = 0 -> FETCH.
  - JUMP(11): pc_write, pc_src = 10 -> FETCH.
  - Encodings 12-15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- opcode is sampled only in DECODE and MEMADR; it must stay stable from DECODE until the instruction completes.
- Cycle counts with MEM_WAIT_EN = 0:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
- Each memory wait cycle adds exactly 1 cycle. mem_ready high outside a memory state is ignored.
- mem_read and mem_write are never high in the same cycle. reg_write and pc_write are never high in the same cycle.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state typedef and state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - ALU-op class constants (ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10)
  - alu_src_b and pc_src select constants
- The ALU control decoder imports the same ALUOP constants.
- One sub-module is natural: mips_ctrl_outdec, a combinational state-to-control-word decoder. The top level keeps only the state register and next-state logic.

Test Plan:
- Reset: rst = 1 for 2 cycles during MEMRD, then release -> state_o = 0 one cycle after the reset edge; reg_write never asserted; FETCH outputs appear on the first cycle after rst deasserts.
- lw, MEM_WAIT_EN = 1, mem_ready low for 2 cycles in FETCH and 1 cycle in MEMRD -> state sequence 0,0,0,1,2,3,3,4,0; ir_write/pc_write pulse exactly once, in the third FETCH cycle; MEMWB has reg_write = 1 and mem_to_reg = 1.
- R-type, opcode 000000 -> states 0,1,6,7,0; alu_op = 10 in EXEC; reg_write = 1 and reg_dst = 1 in ALUWB.
- beq, opcode 000100 -> states 0,1,8,0; BRANCH has alu_op = 01, pc_write_cond = 1, pc_src = 01, pc_write = 0.
- Illegal opcode 111111 -> states 0,1,0; illegal_op high for exactly the DECODE cycle; no mem_write or reg_write asserted.
- Back-to-back sw then j, MEM_WAIT_EN = 0 -> states 0,1,2,5,0,1,11,0; mem_write = 1 and iord = 1 only in state 5; pc_src = 10 with pc_write = 1 in JUMP.
